math_unit: RTL and testbench

Parametrised, registered successor to the team's combinational 4-bit add/subtract block. It takes two `WIDTH`-bit operands and an opcode through a valid/ready handshake and computes add, subtract, accumulate or accumulator-clear. It returns one registered result per transaction, with carry/borrow, signed-overflow and zero flags. It sits between the operand-select logic and the display/result path, and owns a persistent accumulator register.

---
 rtl/math_unit.sv | 150 +++++++++++++++
 tb/tb_math_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/math_unit.sv
// -----------------------------------------------------------------------------
// math_unit
//   Registered add / subtract / accumulate / accumulator-clear unit with a
//   valid/ready handshake on both sides and a persistent accumulator.
//   One result register: a new transaction is accepted whenever that register
//   is empty or is being drained in the same cycle (full throughput).
//
// Parameters
//   WIDTH      operand, result and accumulator width (>= 2)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand/opcode presented
//   in_ready   unit can accept this cycle (!out_valid || out_ready)
//   op         00 ADD, 01 SUB, 10 ACC (acc + a), 11 CLR (clear accumulator)
//   a, b       operands (b ignored for ACC and CLR)
//   out_valid  result register holds an unconsumed result
//   out_ready  downstream consumes the result
//   result     registered result
//   carry      unsigned carry-out (ADD/ACC) or borrow (SUB), 0 for CLR
//   overflow   two's-complement signed overflow, 0 for CLR
//   zero       result == 0
//   acc        current accumulator value
//
// Build option
//   MATH_UNIT_SAT_EN  when defined, signed overflow clamps result (and the
//                     accumulator for ACC) to the signed limit in the
//                     direction of the true result; carry is still taken
//                     from the unclamped operation. Undefined: wrap only.
// -----------------------------------------------------------------------------
module math_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic [WIDTH-1:0] acc
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic                    r_vld_p1;
  logic        [WIDTH-1:0] r_result_p1;
  logic                    r_carry_p1;
  logic                    r_ovf_p1;
  logic        [WIDTH-1:0] r_acc;

  logic                    w_accept;
  logic signed [WIDTH-1:0] w_x_p0;
  logic signed [WIDTH-1:0] w_y_p0;
  logic        [WIDTH:0]   w_sum_p0;
  logic                    w_ovf_p0;
  logic        [WIDTH-1:0] w_res_p0;

`ifdef MATH_UNIT_SAT_EN
  // Clamp to the signed limit on the side the true result lies. On overflow
  // the true result always has the sign of the first operand.
  function automatic logic [WIDTH-1:0] sat_clamp(
    input logic [WIDTH-1:0] wrapped,
    input logic             ovf,
    input logic             neg_dir
  );
    if (!ovf) begin
      return wrapped;
    end
    if (neg_dir) begin
      return {1'b1, {(WIDTH-1){1'b0}}};
    end
    return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  assign in_ready = !r_vld_p1 || out_ready;
  assign w_accept = in_valid && in_ready;

  // Stage p0: operand select and arithmetic
  always_comb begin
    // ACC reuses the adder with the accumulator as first operand
    w_x_p0   = (op == OP_ACC) ? r_acc : a;
    w_y_p0   = (op == OP_ACC) ? a : b;
    w_sum_p0 = '0;
    w_ovf_p0 = 1'b0;
    case (op)
      OP_ADD, OP_ACC: begin
        w_sum_p0 = {1'b0, w_x_p0} + {1'b0, w_y_p0};
        w_ovf_p0 = (w_x_p0[WIDTH-1] == w_y_p0[WIDTH-1]) &&
                   (w_sum_p0[WIDTH-1] != w_x_p0[WIDTH-1]);
      end
      OP_SUB: begin
        // Bit WIDTH of the extended difference is the borrow (a < b)
        w_sum_p0 = {1'b0, w_x_p0} - {1'b0, w_y_p0};
        w_ovf_p0 = (w_x_p0[WIDTH-1] != w_y_p0[WIDTH-1]) &&
                   (w_sum_p0[WIDTH-1] != w_x_p0[WIDTH-1]);
      end
      default: begin
        w_sum_p0 = '0;
        w_ovf_p0 = 1'b0;
      end
    endcase
`ifdef MATH_UNIT_SAT_EN
    w_res_p0 = sat_clamp(w_sum_p0[WIDTH-1:0], w_ovf_p0, w_x_p0[WIDTH-1]);
`else
    w_res_p0 = w_sum_p0[WIDTH-1:0];
`endif
  end

  // Stage p1: result register and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1    <= 1'b0;
      r_result_p1 <= '0;
      r_carry_p1  <= 1'b0;
      r_ovf_p1    <= 1'b0;
      r_acc       <= '0;
    end else if (w_accept) begin
      r_vld_p1    <= 1'b1;
      r_result_p1 <= w_res_p0;
      r_carry_p1  <= w_sum_p0[WIDTH];
      r_ovf_p1    <= w_ovf_p0;
      // CLR produces a zero result, so ACC and CLR both load w_res_p0
      if (op == OP_ACC || op == OP_CLR) begin
        r_acc <= w_res_p0;
      end
    end else if (out_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign out_valid = r_vld_p1;
  assign result    = r_result_p1;
  assign carry     = r_carry_p1;
  assign overflow  = r_ovf_p1;
  assign zero      = (r_result_p1 == '0);
  assign acc       = r_acc;

endmodule

// File: tb/tb_math_unit.sv
module tb_math_unit;

`ifdef MATH_UNIT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [1:0] op = 2'b00;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] a8 = '0, b8 = '0;

  logic       rdy4, ov4, c4, v4, z4;
  logic [3:0] res4, acc4;
  logic       rdy8, ov8, c8, v8, z8;
  logic [7:0] res8, acc8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  math_unit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4), .op(op),
    .a(a4), .b(b4), .out_valid(ov4), .out_ready(out_ready), .result(res4),
    .carry(c4), .overflow(v4), .zero(z4), .acc(acc4));

  math_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8), .op(op),
    .a(a8), .b(b8), .out_valid(ov8), .out_ready(out_ready), .result(res8),
    .carry(c8), .overflow(v8), .zero(z8), .acc(acc8));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: arithmetic on plain integers with signed range checks
  typedef struct packed { int res; bit c; bit v; } mres_t;

  function automatic mres_t model_op(input int w, input logic [1:0] o, input int x, input int y);
    mres_t r;
    int m, h, sx, sy, u, t;
    m = 1 << w;
    h = m / 2;
    sx = (x >= h) ? x - m : x;
    sy = (y >= h) ? y - m : y;
    r = '0;
    if (o == 2'b11) return r;
    if (o == 2'b01) begin
      u = x - y; t = sx - sy; r.c = (x < y);
    end else begin
      u = x + y; t = sx + sy; r.c = (u >= m);
    end
    r.v = (t >= h) || (t < -h);
    r.res = ((u % m) + m) % m;
    if (SAT && r.v) r.res = (t > 0) ? h - 1 : h;
    return r;
  endfunction

  mres_t m_r[2];
  bit    m_ov[2];
  int    m_acc[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_r[i] <= '0; m_ov[i] <= 1'b0; m_acc[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int w, ai, bi, x, y;
        w  = (i == 1) ? 8 : 4;
        ai = (i == 1) ? int'(a8) : int'(a4);
        bi = (i == 1) ? int'(b8) : int'(b4);
        x  = (op == 2'b10) ? m_acc[i] : ai;
        y  = (op == 2'b10) ? ai : bi;
        if (in_valid && (!m_ov[i] || out_ready)) begin
          m_r[i]  <= model_op(w, op, x, y);
          m_ov[i] <= 1'b1;
          if (op[1]) m_acc[i] <= model_op(w, op, x, y).res;
        end else if (out_ready) begin
          m_ov[i] <= 1'b0;
        end
      end
    end
  end

  task automatic cmp(input string tag, input int i, input logic rdy, input logic ov,
                     input logic [31:0] res, input logic c, input logic v,
                     input logic z, input logic [31:0] ac);
    chk({tag, ".in_ready"},  32'(rdy), 32'(!m_ov[i] || out_ready));
    chk({tag, ".out_valid"}, 32'(ov),  32'(m_ov[i]));
    chk({tag, ".result"},    res,      m_r[i].res);
    chk({tag, ".carry"},     32'(c),   32'(m_r[i].c));
    chk({tag, ".overflow"},  32'(v),   32'(m_r[i].v));
    chk({tag, ".zero"},      32'(z),   32'(m_r[i].res == 0));
    chk({tag, ".acc"},       ac,       m_acc[i]);
  endtask

  always @(negedge clk) begin
    cmp("w4", 0, rdy4, ov4, 32'(res4), c4, v4, z4, 32'(acc4));
    cmp("w8", 1, rdy8, ov8, 32'(res8), c8, v8, z8, 32'(acc8));
  end

  task automatic drive(input logic iv, input logic [1:0] o, input logic [7:0] aa,
                       input logic [7:0] bb, input logic ordy);
    in_valid = iv; op = o; out_ready = ordy;
    a4 = aa[3:0]; b4 = bb[3:0]; a8 = aa; b8 = bb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  logic [3:0] acc_snap;

  initial begin
    #1;
    chk("rst.out_valid", 32'(ov4), 0);
    chk("rst.result", 32'(res4), 0);
    chk("rst.zero", 32'(z4), 1);
    chk("rst.acc", 32'(acc4), 0);
    chk("rst.in_ready", 32'(rdy4), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rel.in_ready", 32'(rdy4), 1);

    drive(1, 2'b00, 8'h07, 8'h01, 1);
    chk("add7p1.result", 32'(res4), SAT ? 7 : 8);
    chk("add7p1.carry", 32'(c4), 0);
    chk("add7p1.ovf", 32'(v4), 1);
    chk("add7p1.zero", 32'(z4), 0);
    drive(1, 2'b00, 8'h0F, 8'h01, 1);
    chk("addF1.result", 32'(res4), 0);
    chk("addF1.carry", 32'(c4), 1);
    chk("addF1.ovf", 32'(v4), 0);
    chk("addF1.zero", 32'(z4), 1);
    drive(1, 2'b01, 8'h03, 8'h05, 1);
    chk("sub35.result", 32'(res4), 14);
    chk("sub35.carry", 32'(c4), 1);
    chk("sub35.ovf", 32'(v4), 0);

    drive(1, 2'b11, 8'h0, 8'h0, 1); chk("accseq0", 32'(res4), 0);
    drive(1, 2'b10, 8'h3, 8'h0, 1); chk("accseq1", 32'(res4), 3);
    drive(1, 2'b10, 8'h4, 8'h0, 1); chk("accseq2", 32'(res4), 7);
    drive(1, 2'b00, 8'h1, 8'h1, 1); chk("accseq3", 32'(res4), 2);
    chk("accseq3.acc", 32'(acc4), 7);
    drive(1, 2'b10, 8'h2, 8'h0, 1); chk("accseq4", 32'(res4), SAT ? 7 : 9);
    chk("accseq.acc", 32'(acc4), SAT ? 7 : 9);

    drive(1, 2'b11, 8'h0, 8'h0, 1);
    drive(1, 2'b10, 8'h5, 8'h0, 1);
    drive(1, 2'b10, 8'h5, 8'h0, 1);
    chk("accsat.result", 32'(res4), SAT ? 7 : 10);
    chk("accsat.ovf", 32'(v4), 1);

    drive(0, 2'b00, 8'h0, 8'h0, 1);
    acc_snap = acc4;
    drive(1, 2'b00, 8'h1, 8'h1, 0);
    chk("bp.first.result", 32'(res4), 2);
    chk("bp.in_ready", 32'(rdy4), 0);
    drive(1, 2'b10, 8'h6, 8'h2, 0);
    chk("bp.acc_hold", 32'(acc4), 32'(acc_snap));
    drive(1, 2'b01, 8'h6, 8'h2, 0);
    chk("bp.hold.result", 32'(res4), 2);
    chk("bp.hold.valid", 32'(ov4), 1);
    drive(1, 2'b01, 8'h6, 8'h2, 1);
    chk("bp.second.result", 32'(res4), 4);
    chk("bp.second.valid", 32'(ov4), 1);
    drive(0, 2'b00, 8'h0, 8'h0, 1);
    chk("bp.drained", 32'(ov4), 0);

    for (int k = 0; k < 8; k++) begin
      drive(1, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1);
      chk("tput.valid4", 32'(ov4), 1);
      chk("tput.valid8", 32'(ov8), 1);
    end

    for (int k = 0; k < 300; k++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    drive(1, 2'b10, 8'h3, 8'h0, 1);
    drive(1, 2'b00, 8'h2, 8'h2, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 32'(ov4), 0);
    chk("midrst.result", 32'(res4), 0);
    chk("midrst.acc", 32'(acc4), 0);
    chk("midrst.zero", 32'(z4), 1);
    chk("midrst.in_ready", 32'(rdy4), 1);
    chk("midrst.acc8", 32'(acc8), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("midrst.rel.in_ready", 32'(rdy4), 1);

    for (int k = 0; k < 50; k++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    drive(0, 2'b00, 8'h0, 8'h0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
